univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register: the next generation of the team's 4-bit shift register, generalised to WIDTH bits with serial inputs and outputs, rotate mode, and a counted burst-shift engine with busy/done handshake. It serves as a stand-alone datapath register and as a serialiser/deserialiser stage between parallel logic and bit-serial links. The parallel output is three-state, gated by an active-high disable `oe` as before.

## Interface
Parameters:
- `WIDTH`, 8, register width in bits (≥2)
- `CNT_W`, 4, width of the burst count input

Ports:
- `clk` input 1: sole clock, rising edge
- `rst` input 1: reset, asynchronous, active-high
- `oe` input 1: output disable; 1 → `q` is high-Z, 0 → `q` drives the register
- `s` input 2: mode; 00 hold, 01 shift right (toward bit 0), 10 shift left, 11 parallel load
- `rot` input 1: 1 → shifts rotate; 0 → serial input fills the vacated bit
- `sin_msb` input 1: fill bit entering bit WIDTH-1 on a right shift
- `sin_lsb` input 1: fill bit entering bit 0 on a left shift
- `d` input WIDTH: parallel load data
- `start` input 1: burst request, sampled only in IDLE
- `cnt` input CNT_W: number of burst shifts
- `q` output WIDTH: register contents, or Z
- `sout_r` output 1: always equals reg[0]
- `sout_l` output 1: always equals reg[WIDTH-1]
- `busy` output 1: burst in progress
- `done` output 1: one-cycle burst completion pulse

## Operation
- Internal register `reg`. Right shift: reg ← {fill, reg[WIDTH-1:1]}; fill = rot ? reg[0] : sin_msb. Left shift: reg ← {reg[WIDTH-2:0], fill}; fill = rot ? reg[WIDTH-1] : sin_lsb.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start=0: `s` applied every edge (hold/right/left/load).
- IDLE, start=1 and s∈{01,10}: latch direction, `rot`, and remaining=cnt. No shift on this edge. Next state is BUSY if cnt≠0, else DONE.
- IDLE, start=1 and s∈{00,11}: start is ignored and `s` acts normally.
- BUSY: every edge shifts in the latched direction and decrements remaining. The `s`, `d` and `start` inputs are ignored. `rot` is latched, but `sin_msb`/`sin_lsb` are sampled live each edge. When remaining reaches 0 after a shift, next state is DONE.
- DONE: reg holds, done=1, next state is IDLE unconditionally.
- Counts larger than WIDTH are legal; the register simply keeps shifting/rotating.
- `oe` affects only the `q` driver. It never affects the register, the FSM, or the serial outputs.

## Timing
- Reset values: reg=0, state=IDLE, busy=0, done=0, sout_r=sout_l=0. `q` is 0 if oe=0, else Z.
- Reset asserted mid-burst: abort immediately to the reset values; no done pulse.
- Single-cycle modes: result is visible on `q` one edge after sampling.
- Burst accepted at edge E0: shifts occur at edges E0+1 … E0+cnt. busy=1 from after E0 until after E0+cnt. done=1 for exactly the cycle after E0+cnt, then IDLE.
- Burst with cnt=0: done=1 in the cycle after E0 and busy never asserts.
- A start held high in the DONE cycle is ignored. It is honoured on the first IDLE cycle, so back-to-back bursts are spaced by one DONE cycle.
- Outputs are purely registered. The only combinational paths are the serial taps and the `oe` → `q` driver.

## Structure
- Package `univ_shift_pkg`:
  - mode constants S_HOLD=2'b00, S_SHR=2'b01, S_SHL=2'b10, S_LOAD=2'b11
  - state enum IDLE/BUSY/DONE
- Sub-module `univ_shift_step` (combinational, parametrised WIDTH): takes reg, direction, rot and fill bits; returns the next register value. It is shared by the single-step and burst paths.
- Top module `univ_shift_reg` holds the register, FSM, count register and three-state driver.

## Test plan
- WIDTH=4, after reset with oe=1 → q=ZZZZ. Then oe=0 → q=0000. Then s=11, d=1010 for one edge → q=1010.
- WIDTH=4 starting from q=1010, rot=0, sin_msb=0: s=01 for two edges gives 0101 then 0010. Then s=10 with sin_lsb=1 gives 0101 then 1011.
- WIDTH=8 burst, rot=1: load 8'h81, then start with s=01 and cnt=3 → busy high for 3 cycles, q=8'h30, done pulses once. Toggling `s` during the burst has no effect.
- cnt=0 burst → done the cycle after start, busy stays 0, q unchanged. Start with s=11 → plain load, no busy, no done.
- Reset mid-burst: WIDTH=8 with cnt=10, assert rst asynchronously after 4 shifts → q=0, busy=0 immediately, no done pulse. After release the block accepts a new burst.
- Serial loopback, WIDTH=8: shift-left a byte out via sout_l into a second instance's sin_msb with s=01, 8 edges each → receiver q equals the transmitted byte bit-reversed.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared definitions for the universal shift register.
//   S_* : mode encodings for the 2-bit mode input
//   state_e : burst FSM states
package univ_shift_pkg;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/univ_shift_step.sv
// One-position shift/rotate of a WIDTH-bit value (combinational).
//   cur     : current register value
//   left    : 1 = shift toward MSB, 0 = shift toward bit 0
//   rot     : 1 = the bit shifted out re-enters at the other end
//   sin_msb : fill for bit WIDTH-1 on a right shift when not rotating
//   sin_lsb : fill for bit 0 on a left shift when not rotating
//   nxt     : shifted value
module univ_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             left,
  input  logic             rot,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    if (left) begin
      nxt = {cur[WIDTH-2:0], (rot ? cur[WIDTH-1] : sin_lsb)};
    end else begin
      nxt = {(rot ? cur[0] : sin_msb), cur[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with counted burst-shift engine.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   oe              : 1 releases q to high-Z; register is unaffected
//   s               : mode (hold / shift right / shift left / load)
//   rot             : rotate instead of serial fill
//   sin_msb/sin_lsb : serial fill bits for right/left shifts
//   d               : parallel load data
//   start, cnt      : burst request and shift count (sampled in IDLE)
//   q               : register contents or Z
//   sout_r, sout_l  : serial taps, reg[0] and reg[WIDTH-1]
//   busy, done      : burst in progress / one-cycle completion pulse
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic [1:0]       s,
  input  logic             rot,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] shreg_q, shreg_d, step_val;
  logic [CNT_W-1:0] rem_q, rem_d;
  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             step_left, step_rot;

  // A single shifter serves both paths: a burst uses the latched direction and
  // rotate flag, idle-mode shifts use the live inputs (s[1] set means left).
  assign step_left = (state_q == BUSY) ? dir_q : s[1];
  assign step_rot  = (state_q == BUSY) ? rot_q : rot;

  univ_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur     (shreg_q),
    .left    (step_left),
    .rot     (step_rot),
    .sin_msb (sin_msb),
    .sin_lsb (sin_lsb),
    .nxt     (step_val)
  );

  always_comb begin
    shreg_d = shreg_q;
    rem_d   = rem_q;
    state_d = state_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (start && (s == S_SHR || s == S_SHL)) begin
          // Acceptance edge only latches the burst; the first shift is next edge.
          dir_d   = (s == S_SHL);
          rot_d   = rot;
          rem_d   = cnt;
          state_d = (cnt != '0) ? BUSY : DONE;
        end else begin
          case (s)
            S_HOLD:       shreg_d = shreg_q;
            S_SHR, S_SHL: shreg_d = step_val;
            S_LOAD:       shreg_d = d;
            default:      shreg_d = shreg_q;
          endcase
        end
      end
      BUSY: begin
        shreg_d = step_val;
        rem_d   = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      rem_q   <= '0;
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign sout_r = shreg_q[0];
  assign sout_l = shreg_q[WIDTH-1];
  assign q      = oe ? {WIDTH{1'bz}} : shreg_q;

endmodule
